// File: rtl/seq_pkg.sv
// Shared types and constants for the register-file/ALU micro-op sequencer.
package seq_pkg;
    localparam int DATA_W = 4;
    localparam int ADDR_W = 2;
    localparam int OP_W   = 3;

    localparam logic [OP_W-1:0] OP_LDI = 3'd6;
    localparam logic [OP_W-1:0] OP_NOP = 3'd7;

    // Sequencer states {IDLE, READ, EXEC, WB}
    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t READ = 2'd1;
    localparam state_t EXEC = 2'd2;
    localparam state_t WB   = 2'd3;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [ADDR_W-1:0] rd;
        logic [ADDR_W-1:0] rs1;
        logic [ADDR_W-1:0] rs2;
        logic [DATA_W-1:0] imm;
    } uop_t;
endpackage

// File: rtl/seq_if.sv
// Sequencer bus: micro-op handshake, register-file ports, ALU ports, status and debug state.
interface seq_if;
    import seq_pkg::*;

    // Handshake: a micro-op transfers on a posedge where in_valid and in_ready are both high;
    // in_ready depends only on sequencer state, never on in_valid, and in_* are ignored otherwise.
    logic              in_valid;
    logic              in_ready;
    logic [OP_W-1:0]   in_op;
    logic [ADDR_W-1:0] in_rd;
    logic [ADDR_W-1:0] in_rs1;
    logic [ADDR_W-1:0] in_rs2;
    logic [DATA_W-1:0] in_imm;
    logic [ADDR_W-1:0] read_addr1;
    logic [ADDR_W-1:0] read_addr2;
    logic [DATA_W-1:0] read_data1;
    logic [DATA_W-1:0] read_data2;
    logic [ADDR_W-1:0] write_addr;
    logic [DATA_W-1:0] write_data;
    logic              reg_write;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [OP_W-1:0]   alu_op;
    logic [DATA_W-1:0] alu_result;
    logic              busy;
    logic              done;
    state_t            dbg_state;

    modport master (
        input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm,
        input  read_data1, read_data2, alu_result,
        output in_ready, read_addr1, read_addr2, write_addr, write_data, reg_write,
        output alu_a, alu_b, alu_op, busy, done, dbg_state
    );

    modport slave (
        output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm,
        output read_data1, read_data2, alu_result,
        input  in_ready, read_addr1, read_addr2, write_addr, write_data, reg_write,
        input  alu_a, alu_b, alu_op, busy, done, dbg_state
    );
endinterface

// File: rtl/seq_uop_buf.sv
// One-entry micro-op holding register with valid/ready on the push side.
module seq_uop_buf
    import seq_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic push_valid,
    output logic push_ready,
    input  uop_t push_uop,
    output logic pop_valid,
    output uop_t pop_uop,
    input  logic pop
);
    logic full;
    uop_t data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full   <= 1'b0;
            data_q <= '0;
        end else if (push_valid && push_ready) begin
            full   <= 1'b1;
            data_q <= push_uop;
        end else if (pop) begin
            full <= 1'b0;
        end
    end

    assign push_ready = !full;
    assign pop_valid  = full;
    assign pop_uop    = data_q;
endmodule

// File: rtl/regfile_alu_sequencer.sv
// Multi-cycle sequencer: one micro-op at a time through READ/EXEC/WB on an external regfile and ALU.
// Optional SEQ_SKID_BUF_EN adds a one-entry buffer so a micro-op can be accepted while busy.
module regfile_alu_sequencer
    import seq_pkg::*;
(
    input logic clk,
    input logic rst_n,
    seq_if.master bus
);
    state_t            state;
    logic [OP_W-1:0]   cur_op;
    logic [ADDR_W-1:0] cur_rd;
    logic [ADDR_W-1:0] read_addr1_q, read_addr2_q, write_addr_q;
    logic [DATA_W-1:0] write_data_q, alu_a_q, alu_b_q;
    logic [OP_W-1:0]   alu_op_q;
    logic              nop_done;
    uop_t              in_uop, disp_uop;
    logic              disp_valid;

    assign in_uop = '{op: bus.in_op, rd: bus.in_rd, rs1: bus.in_rs1, rs2: bus.in_rs2, imm: bus.in_imm};

`ifdef SEQ_SKID_BUF_EN
    logic buf_ready, buf_valid;
    uop_t buf_uop;

    // A buffered micro-op wins over the input port; while it is held, in_ready is low.
    seq_uop_buf u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_valid (bus.in_valid && (state != IDLE)),
        .push_ready (buf_ready),
        .push_uop   (in_uop),
        .pop_valid  (buf_valid),
        .pop_uop    (buf_uop),
        .pop        ((state == IDLE) && buf_valid)
    );

    assign bus.in_ready = buf_ready;
    assign disp_valid   = (state == IDLE) && (buf_valid || bus.in_valid);
    assign disp_uop     = buf_valid ? buf_uop : in_uop;
`else
    assign bus.in_ready = (state == IDLE);
    assign disp_valid   = bus.in_valid && (state == IDLE);
    assign disp_uop     = in_uop;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cur_op       <= '0;
            cur_rd       <= '0;
            read_addr1_q <= '0;
            read_addr2_q <= '0;
            write_addr_q <= '0;
            write_data_q <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            nop_done     <= 1'b0;
        end else begin
            nop_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (disp_valid) begin
                        if (disp_uop.op == OP_NOP) begin
                            nop_done <= 1'b1;
                        end else if (disp_uop.op == OP_LDI) begin
                            write_addr_q <= disp_uop.rd;
                            write_data_q <= disp_uop.imm;
                            state        <= WB;
                        end else begin
                            cur_op       <= disp_uop.op;
                            cur_rd       <= disp_uop.rd;
                            read_addr1_q <= disp_uop.rs1;
                            read_addr2_q <= disp_uop.rs2;
                            state        <= READ;
                        end
                    end
                end
                READ: begin
                    alu_a_q  <= bus.read_data1;
                    alu_b_q  <= bus.read_data2;
                    alu_op_q <= cur_op;
                    state    <= EXEC;
                end
                EXEC: begin
                    write_data_q <= bus.alu_result;
                    write_addr_q <= cur_rd;
                    state        <= WB;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.read_addr1 = read_addr1_q;
    assign bus.read_addr2 = read_addr2_q;
    assign bus.write_addr = write_addr_q;
    assign bus.write_data = write_data_q;
    assign bus.reg_write  = (state == WB);
    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.alu_op     = alu_op_q;
    assign bus.busy       = (state != IDLE);
    assign bus.done       = (state == WB) || nop_done;
    assign bus.dbg_state  = state;
endmodule

// File: tb/tb_regfile_alu_sequencer.sv
// Bench for regfile_alu_sequencer: environment regfile + ALU, vector table, hand sequences, scoreboard.
module tb_regfile_alu_sequencer;
    import seq_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    seq_if bus ();
    regfile_alu_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    logic [3:0] rf     [4] = '{default: 4'h0};
    logic [3:0] ref_rf [4] = '{default: 4'h0};

    function automatic logic [3:0] alu_f(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return {a[2:0], 1'b0};
            default: return 4'h0;
        endcase
    endfunction

    function automatic int lat_of(input logic [2:0] op);
        return (op == OP_LDI || op == OP_NOP) ? 1 : 3;
    endfunction

    assign bus.read_data1 = rf[bus.read_addr1];
    assign bus.read_data2 = rf[bus.read_addr2];
    assign bus.alu_result = alu_f(bus.alu_op, bus.alu_a, bus.alu_b);
    always @(posedge clk) if (bus.reg_write) rf[bus.write_addr] <= bus.write_data;

    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;
    logic [5:0] exp_q[$];
    int done_q[$];
    logic [5:0] mon_e;
    int mon_d;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Scoreboard: writes and done pulses are compared against expectations pushed at accept.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (bus.reg_write) begin
            if (exp_q.size() == 0) check("write_without_expectation", 1, 0);
            else begin
                mon_e = exp_q.pop_front();
                check("write_addr_data", int'({bus.write_addr, bus.write_data}), int'(mon_e));
            end
        end
        if (bus.done) begin
            if (done_q.size() == 0) check("done_without_expectation", 1, 0);
            else begin
                mon_d = done_q.pop_front();
                check("done_cycle", cyc, mon_d);
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic send(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                        input logic [1:0] rs2, input logic [3:0] imm, input bit wr,
                        input logic [3:0] data, input int lat, input bit track, output int acc);
        int guard = 0;
        bus.in_valid = 1'b1;
        bus.in_op = op; bus.in_rd = rd; bus.in_rs1 = rs1; bus.in_rs2 = rs2; bus.in_imm = imm;
        while (!bus.in_ready) begin
            @(negedge clk);
            guard++;
            if (guard > 40) begin
                check("accept_timeout", 0, 1);
                bus.in_valid = 1'b0;
                acc = -1;
                return;
            end
        end
        @(posedge clk);
        acc = cyc;
        if (track) begin
            if (wr) begin
                exp_q.push_back({rd, data});
                ref_rf[rd] = data;
            end
            done_q.push_back(acc + lat);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        bit ok;
        do begin
            @(negedge clk);
            n++;
            ok = !bus.busy && exp_q.size() == 0 && done_q.size() == 0;
        end while (!ok && n < 40);
        check("drain", int'(ok), 1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_in_ready"}, int'(bus.in_ready), 1);
        check({tag, "_busy"}, int'(bus.busy), 0);
        check({tag, "_done"}, int'(bus.done), 0);
        check({tag, "_reg_write"}, int'(bus.reg_write), 0);
        check({tag, "_read_addrs"}, int'({bus.read_addr1, bus.read_addr2}), 0);
        check({tag, "_write_addr_data"}, int'({bus.write_addr, bus.write_data}), 0);
        check({tag, "_alu_ab_op"}, int'({bus.alu_a, bus.alu_b, bus.alu_op}), 0);
        check({tag, "_state"}, int'(bus.dbg_state), int'(IDLE));
    endtask

    typedef struct {
        logic [2:0] op;
        logic [1:0] rd, rs1, rs2;
        logic [3:0] imm;
        bit         wr;
        logic [3:0] data;
    } vec_t;
    vec_t tbl [12];

    int acc1, acc2, acc_tmp;
    logic [3:0] old0;
    logic [2:0] r_op;
    logic [1:0] r_rd, r_rs1, r_rs2;
    logic [3:0] r_imm, r_data;

    initial begin
        bus.in_valid = 1'b0; bus.in_op = '0; bus.in_rd = '0;
        bus.in_rs1 = '0; bus.in_rs2 = '0; bus.in_imm = '0;
        // Running regfile contents are noted per row, starting from all zero.
        tbl[0]  = '{OP_LDI, 2'd2, 2'd0, 2'd0, 4'hA, 1'b1, 4'hA};
        tbl[1]  = '{OP_LDI, 2'd1, 2'd0, 2'd0, 4'h3, 1'b1, 4'h3};
        tbl[2]  = '{OP_LDI, 2'd2, 2'd0, 2'd0, 4'h5, 1'b1, 4'h5};
        tbl[3]  = '{3'd0,   2'd3, 2'd1, 2'd2, 4'h0, 1'b1, 4'h8};  // 3+5
        tbl[4]  = '{OP_NOP, 2'd1, 2'd0, 2'd0, 4'hF, 1'b0, 4'h0};
        tbl[5]  = '{3'd1,   2'd0, 2'd3, 2'd1, 4'h0, 1'b1, 4'h5};  // 8-3
        tbl[6]  = '{3'd2,   2'd1, 2'd3, 2'd0, 4'h0, 1'b1, 4'h0};  // 8&5
        tbl[7]  = '{3'd3,   2'd1, 2'd2, 2'd3, 4'h0, 1'b1, 4'hD};  // 5|8
        tbl[8]  = '{3'd4,   2'd2, 2'd1, 2'd2, 4'h0, 1'b1, 4'h8};  // D^5
        tbl[9]  = '{3'd5,   2'd3, 2'd1, 2'd0, 4'h0, 1'b1, 4'hA};  // D<<1
        tbl[10] = '{3'd0,   2'd3, 2'd3, 2'd3, 4'h0, 1'b1, 4'h4};  // A+A wraps
        tbl[11] = '{3'd1,   2'd0, 2'd0, 2'd1, 4'h0, 1'b1, 4'h8};  // 5-D wraps

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("in_reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("after_reset");

        for (int i = 0; i < 12; i++) begin
            send(tbl[i].op, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].imm,
                 tbl[i].wr, tbl[i].data, lat_of(tbl[i].op), 1'b1, acc_tmp);
            wait_idle();
        end
        check("busy_after_table", int'(bus.busy), 0);
        check("rf_after_table", int'({rf[3], rf[2], rf[1], rf[0]}), 16'h48D8);

        // ALU add with per-stage observation
        send(OP_LDI, 2'd1, 2'd0, 2'd0, 4'h3, 1'b1, 4'h3, 1, 1'b1, acc_tmp); wait_idle();
        send(OP_LDI, 2'd2, 2'd0, 2'd0, 4'h5, 1'b1, 4'h5, 1, 1'b1, acc_tmp); wait_idle();
        send(3'd0, 2'd3, 2'd1, 2'd2, 4'h0, 1'b1, 4'h8, 3, 1'b1, acc1);
        check("read_stage_addrs", int'({bus.read_addr1, bus.read_addr2}), int'({2'd1, 2'd2}));
        check("read_stage_state", int'(bus.dbg_state), int'(READ));
        check("read_stage_busy", int'(bus.busy), 1);
        @(negedge clk);
        check("exec_stage_operands", int'({bus.alu_a, bus.alu_b, bus.alu_op}), int'({4'h3, 4'h5, 3'd0}));
        check("exec_stage_state", int'(bus.dbg_state), int'(EXEC));
        @(negedge clk);
        check("wb_stage_write", int'({bus.reg_write, bus.write_addr, bus.write_data}), int'({1'b1, 2'd3, 4'h8}));
        wait_idle();

`ifndef SEQ_SKID_BUF_EN
        // Second micro-op held on the port while busy is only taken once IDLE
        send(3'd3, 2'd0, 2'd1, 2'd2, 4'h0, 1'b1, 4'h7, 3, 1'b1, acc1);
        bus.in_valid = 1'b1; bus.in_op = 3'd4; bus.in_rd = 2'd1; bus.in_rs1 = 2'd0; bus.in_rs2 = 2'd3;
        for (int k = 0; k < 3; k++) begin
            check("in_ready_low_while_busy", int'(bus.in_ready), 0);
            @(negedge clk);
        end
        send(3'd4, 2'd1, 2'd0, 2'd3, 4'h0, 1'b1, 4'hF, 3, 1'b1, acc2);
        check("second_accept_cycle", acc2, acc1 + 4);
        wait_idle();
`else
        // Back-to-back ALU ops through the buffer
        send(3'd0, 2'd3, 2'd1, 2'd2, 4'h0, 1'b1, 4'h8, 3, 1'b1, acc1);
        send(3'd4, 2'd2, 2'd3, 2'd1, 4'h0, 1'b1, 4'hB, 6, 1'b1, acc2);
        check("buffered_accept_cycle", acc2, acc1 + 1);
        for (int k = 0; k < 3; k++) begin
            check("in_ready_low_while_buffer_full", int'(bus.in_ready), 0);
            @(negedge clk);
        end
        check("in_ready_after_dispatch", int'(bus.in_ready), 1);
        wait_idle();
`endif

        // NOP retires next cycle without a write
        send(OP_NOP, 2'd1, 2'd0, 2'd0, 4'h0, 1'b0, 4'h0, 1, 1'b1, acc_tmp);
        check("nop_done", int'(bus.done), 1);
        check("nop_no_write", int'(bus.reg_write), 0);
        check("nop_not_busy", int'(bus.busy), 0);
        wait_idle();

        // Reset during EXEC of an op that would write r0=F
        send(OP_LDI, 2'd1, 2'd0, 2'd0, 4'hF, 1'b1, 4'hF, 1, 1'b1, acc_tmp); wait_idle();
        send(OP_LDI, 2'd2, 2'd0, 2'd0, 4'h0, 1'b1, 4'h0, 1, 1'b1, acc_tmp); wait_idle();
        old0 = ref_rf[0];
        send(3'd0, 2'd0, 2'd1, 2'd2, 4'h0, 1'b0, 4'h0, 3, 1'b0, acc_tmp);
        @(negedge clk);
        check("abort_in_exec", int'(bus.dbg_state), int'(EXEC));
        rst_n = 1'b0;
        #1 check_idle_outputs("abort");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_r0_unchanged", int'(rf[0]), int'(old0));
        check("abort_ready", int'(bus.in_ready), 1);

        // Random micro-ops against the reference register model
        for (int i = 0; i < 16; i++) begin
            r_op = 3'($urandom_range(0, 7));
            r_rd = 2'($urandom_range(0, 3));
            r_rs1 = 2'($urandom_range(0, 3));
            r_rs2 = 2'($urandom_range(0, 3));
            r_imm = 4'($urandom_range(0, 15));
            r_data = (r_op == OP_LDI) ? r_imm : alu_f(r_op, ref_rf[r_rs1], ref_rf[r_rs2]);
            send(r_op, r_rd, r_rs1, r_rs2, r_imm, r_op != OP_NOP, r_data, lat_of(r_op), 1'b1, acc_tmp);
            wait_idle();
        end
        check("rf_matches_model", int'({rf[3], rf[2], rf[1], rf[0]}),
              int'({ref_rf[3], ref_rf[2], ref_rf[1], ref_rf[0]}));
        check("queues_drained", exp_q.size() + done_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end
endmodule
